// File: rtl/pll_clk_enables.sv
// Clocking back-end behind the PLL: qualifies lock, sequences the system reset
// and produces NUM_CH fractional clock-enable streams from phase accumulators.
module pll_clk_enables #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 24,
    parameter int LOCK_FILTER = 1024,
    parameter int RST_HOLD    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pll_lock,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    input  logic [NUM_CH-1:0]       ch_run,
    output logic [NUM_CH-1:0]       ce,
    output logic                    sys_reset,
    output logic                    ready
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic          lock_meta_reg;
    logic          lock_s_reg;
    state_t        state_reg;
    state_t        state_next;
    logic [FW-1:0] filt_cnt_reg;
    logic [FW-1:0] filt_cnt_next;
    logic [HW-1:0] hold_cnt_reg;
    logic [HW-1:0] hold_cnt_next;
    logic          sys_reset_reg;
    logic          sys_reset_next;
    logic          ready_reg;
    logic          ready_next;
    logic          run_stay;

    // pll_lock is asynchronous to clk, so it only enters the logic via lock_s_reg
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= pll_lock;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= WAIT_LOCK;
            filt_cnt_reg <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            filt_cnt_reg <= filt_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        filt_cnt_next = filt_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        unique case (state_reg)
            WAIT_LOCK: begin
                if (lock_s_reg) begin
                    state_next    = FILTER;
                    filt_cnt_next = '0;
                end
            end
            FILTER: begin
                if (!lock_s_reg) begin
                    state_next = WAIT_LOCK;
                end else if (filt_cnt_reg == FILT_LAST) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end else begin
                    filt_cnt_next = filt_cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s_reg) begin
                    state_next = WAIT_LOCK;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s_reg) begin
                    state_next = WAIT_LOCK;
                end
            end
            default: state_next = WAIT_LOCK;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM
    always_comb begin
        sys_reset_next = (state_next != RUN);
        ready_next     = (state_next == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sys_reset_reg <= 1'b1;
            ready_reg     <= 1'b0;
        end else begin
            sys_reset_reg <= sys_reset_next;
            ready_reg     <= ready_next;
        end
    end

    assign sys_reset = sys_reset_reg;
    assign ready     = ready_reg;

    // The edge that leaves RUN already clears the accumulators and forces ce low
    assign run_stay = (state_reg == RUN) && (state_next == RUN);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_W-1:0] acc_reg;
            logic             ce_reg;
            logic [ACC_W:0]   sum;

            assign sum = {1'b0, acc_reg} + {1'b0, inc[gi*ACC_W +: ACC_W]};

            always_ff @(posedge clk) begin
                if (reset || !run_stay) begin
                    acc_reg <= '0;
                    ce_reg  <= 1'b0;
                end else if (ch_run[gi]) begin
                    acc_reg <= sum[ACC_W-1:0];
                    ce_reg  <= sum[ACC_W];
                end else begin
                    ce_reg  <= 1'b0;
                end
            end

            assign ce[gi] = ce_reg;
        end
    endgenerate

endmodule
